// File: rtl/frame_aggregate.sv
// Captures the first OUT_W bits of each qualifying frame from a narrow beat stream
// into a ready/valid holding register, with saturating runt/drop/bad-FCS statistics.
module frame_aggregate #(
    parameter int IN_W        = 2,
    parameter int OUT_W       = 44,
    parameter int MIN_BEATS   = 44,
    parameter int EMIT_AT_END = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [IN_W-1:0]  axiid,
    input  logic             fcs_ok,
    input  logic             axior,
    output logic [OUT_W-1:0] axiod,
    output logic             axiov,
    output logic [CNT_W-1:0] runt_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] bad_fcs_count
);

    localparam int CAP_BEATS = OUT_W / IN_W;
    localparam int BCNT_W    = $clog2(MIN_BEATS + 1);
    localparam logic [BCNT_W-1:0] CAP_C = BCNT_W'(CAP_BEATS);
    localparam logic [BCNT_W-1:0] MIN_C = BCNT_W'(MIN_BEATS);

    typedef enum logic [1:0] {SYNC, CAPTURE, COUNT, TAIL} state_t;

    state_t             state_q, state_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d, bcnt_inc;
    logic [OUT_W-1:0]   data_q, data_d, shifted, emit_word;
    logic [OUT_W-1:0]   axiod_q, axiod_d;
    logic               axiov_q, axiov_d;
    logic [CNT_W-1:0]   runt_q, runt_d, drop_q, drop_d, bad_q, bad_d;
    logic               emit, runt_inc, bad_inc, drop_inc;

    always_comb begin
        state_d   = state_q;
        bcnt_d    = bcnt_q;
        data_d    = data_q;
        bcnt_inc  = bcnt_q + 1'b1;
        shifted   = OUT_W'({data_q, axiid});
        emit      = 1'b0;
        emit_word = data_q;
        runt_inc  = 1'b0;
        bad_inc   = 1'b0;

        case (state_q)
            SYNC: begin
                if (!axiiv) state_d = CAPTURE;
            end
            CAPTURE: begin
                if (axiiv) begin
                    data_d    = shifted;
                    bcnt_d    = bcnt_inc;
                    emit_word = shifted;
                    // MIN_BEATS == CAP_BEATS qualifies here and skips COUNT
                    if (bcnt_inc == MIN_C) begin
                        state_d = TAIL;
                        emit    = (EMIT_AT_END == 0);
                    end else if (bcnt_inc == CAP_C) begin
                        state_d = COUNT;
                    end
                end else if (bcnt_q != '0) begin
                    runt_inc = 1'b1;
                    bcnt_d   = '0;
                    data_d   = '0;
                end
            end
            COUNT: begin
                if (axiiv) begin
                    bcnt_d = bcnt_inc;
                    if (bcnt_inc == MIN_C) begin
                        state_d = TAIL;
                        emit    = (EMIT_AT_END == 0);
                    end
                end else begin
                    runt_inc = 1'b1;
                    bcnt_d   = '0;
                    data_d   = '0;
                    state_d  = CAPTURE;
                end
            end
            TAIL: begin
                if (!axiiv) begin
                    bcnt_d  = '0;
                    data_d  = '0;
                    state_d = CAPTURE;
                    if (EMIT_AT_END != 0) begin
                        if (fcs_ok) emit = 1'b1;
                        else        bad_inc = 1'b1;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    // A held word is never overwritten; a reload is only allowed alongside an accept.
    always_comb begin
        axiov_d  = axiov_q;
        axiod_d  = axiod_q;
        drop_inc = 1'b0;
        if (emit && (!axiov_q || axior)) begin
            axiov_d = 1'b1;
            axiod_d = emit_word;
        end else begin
            if (emit) drop_inc = 1'b1;
            if (axiov_q && axior) axiov_d = 1'b0;
        end
    end

    always_comb begin
        runt_d = runt_q;
        drop_d = drop_q;
        bad_d  = bad_q;
        if (runt_inc && runt_q != '1) runt_d = runt_q + CNT_W'(1);
        if (drop_inc && drop_q != '1) drop_d = drop_q + CNT_W'(1);
        if (bad_inc  && bad_q  != '1) bad_d  = bad_q  + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SYNC;
            bcnt_q  <= '0;
            data_q  <= '0;
            axiod_q <= '0;
            axiov_q <= 1'b0;
            runt_q  <= '0;
            drop_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            data_q  <= data_d;
            axiod_q <= axiod_d;
            axiov_q <= axiov_d;
            runt_q  <= runt_d;
            drop_q  <= drop_d;
            bad_q   <= bad_d;
        end
    end

    assign axiod         = axiod_q;
    assign axiov         = axiov_q;
    assign runt_count    = runt_q;
    assign drop_count    = drop_q;
    assign bad_fcs_count = bad_q;

endmodule

// File: tb/tb_frame_aggregate.sv
// Bench for frame_aggregate: three instances (default, emit-at-end, MIN_BEATS==CAP_BEATS)
// checked every cycle against a frame-level reference model, plus directed scenarios.
module tb_frame_aggregate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, iv = 1'b0, fcs = 1'b0, rdy = 1'b0;
    logic [1:0] d = '0;

    logic        ov[3];
    logic [43:0] od[3];
    logic [15:0] rc[3], dc[3], bc[3];

    int checks = 0;
    int errors = 0;

    frame_aggregate u_def (
        .clk(clk), .rst(rst), .axiiv(iv), .axiid(d), .fcs_ok(fcs), .axior(rdy),
        .axiod(od[0]), .axiov(ov[0]), .runt_count(rc[0]), .drop_count(dc[0]), .bad_fcs_count(bc[0])
    );
    frame_aggregate #(.EMIT_AT_END(1)) u_end (
        .clk(clk), .rst(rst), .axiiv(iv), .axiid(d), .fcs_ok(fcs), .axior(rdy),
        .axiod(od[1]), .axiov(ov[1]), .runt_count(rc[1]), .drop_count(dc[1]), .bad_fcs_count(bc[1])
    );
    frame_aggregate #(.MIN_BEATS(22)) u_min (
        .clk(clk), .rst(rst), .axiiv(iv), .axiid(d), .fcs_ok(fcs), .axior(rdy),
        .axiod(od[2]), .axiov(ov[2]), .runt_count(rc[2]), .drop_count(dc[2]), .bad_fcs_count(bc[2])
    );

    // Frame-level reference: beats seen this frame, captured prefix, output slot, counters.
    typedef struct {
        bit          synced;
        int          beats;
        logic [43:0] word;
        bit          ov;
        logic [43:0] od;
        int          runt;
        int          drop;
        int          bad;
    } model_t;

    model_t m[3];
    int     min_of[3] = '{44, 44, 22};
    bit     eae_of[3] = '{1'b0, 1'b1, 1'b0};

    function automatic int sat(int x);
        return (x < 65535) ? x + 1 : x;
    endfunction

    function automatic model_t step(model_t s, bit eae, int min, bit r, bit v,
                                    logic [1:0] dd, bit f, bit rd);
        model_t      n = s;
        bit          emit = 1'b0;
        logic [43:0] ew = '0;
        if (r) begin
            n = '{default: '0};
            return n;
        end
        if (!n.synced) begin
            if (!v) n.synced = 1'b1;
        end else if (v) begin
            if (n.beats < min) begin
                n.beats++;
                if (n.beats <= 22) n.word = {n.word[41:0], dd};
                if (n.beats == min && !eae) begin
                    emit = 1'b1;
                    ew   = n.word;
                end
            end
        end else begin
            if (n.beats > 0 && n.beats < min) n.runt = sat(n.runt);
            else if (n.beats == min && eae) begin
                if (f) begin
                    emit = 1'b1;
                    ew   = n.word;
                end else n.bad = sat(n.bad);
            end
            n.beats = 0;
            n.word  = '0;
        end
        if (emit) begin
            if (!n.ov || rd) begin
                n.ov = 1'b1;
                n.od = ew;
            end else n.drop = sat(n.drop);
        end else if (n.ov && rd) n.ov = 1'b0;
        return n;
    endfunction

    always @(posedge clk)
        for (int i = 0; i < 3; i++)
            m[i] <= step(m[i], eae_of[i], min_of[i], rst, iv, d, fcs, rdy);

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("axiov[%0d]", i), 64'(ov[i]), 64'(m[i].ov));
            check_eq($sformatf("axiod[%0d]", i), 64'(od[i]), 64'(m[i].od));
            check_eq($sformatf("runt[%0d]", i), 64'(rc[i]), 64'(m[i].runt));
            check_eq($sformatf("drop[%0d]", i), 64'(dc[i]), 64'(m[i].drop));
            check_eq($sformatf("bad[%0d]", i), 64'(bc[i]), 64'(m[i].bad));
        end
    endtask

    // rd_mode: 0 = ready low, 1 = ready high, 2 = random per cycle
    task automatic cycle(input bit r, input bit v, input logic [1:0] dd, input bit f, input int rd_mode);
        @(negedge clk);
        check_all();
        rst = r;
        iv  = v;
        d   = dd;
        fcs = f;
        rdy = (rd_mode == 2) ? 1'($urandom_range(0, 1)) : (rd_mode != 0);
    endtask

    task automatic idle(input int n, input int rd_mode);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 2'b00, 1'b0, rd_mode);
    endtask

    task automatic send_frame(input int n, input logic [43:0] w, input bit f, input int rd_mode,
                              input int rst_beats, input int pulse_beat);
        logic [1:0] b;
        for (int k = 0; k < n; k++) begin
            b = (k < 22) ? w[43 - 2*k -: 2] : 2'($urandom_range(0, 3));
            cycle(k < rst_beats, 1'b1, b, 1'b0, (k == pulse_beat) ? 1 : rd_mode);
        end
        cycle(1'b0, 1'b0, 2'b00, f, rd_mode);
    endtask

    initial begin
        logic [43:0] w;
        int          n, rb;

        repeat (3) @(negedge clk);
        check_eq("rst_axiov", 64'(ov[0]), 64'd0);
        check_eq("rst_axiod", 64'(od[0]), 64'd0);
        check_eq("rst_runt", 64'(rc[0]), 64'd0);
        check_eq("rst_drop", 64'(dc[1]), 64'd0);
        check_eq("rst_bad", 64'(bc[1]), 64'd0);
        cycle(1'b0, 1'b0, 2'b00, 1'b0, 1);
        idle(2, 1);

        // 22 beats of 10 then 22 of 01: only the first 22 are captured
        for (int k = 0; k < 22; k++) cycle(1'b0, 1'b1, 2'b10, 1'b0, 1);
        for (int k = 0; k < 22; k++) cycle(1'b0, 1'b1, 2'b01, 1'b0, 1);
        cycle(1'b0, 1'b0, 2'b00, 1'b1, 1);
        check_eq("s1_valid", 64'(ov[0]), 64'd1);
        check_eq("s1_word", 64'(od[0]), 64'h0AAAAAAAAAAA);
        idle(1, 1);
        check_eq("s1_one_cycle", 64'(ov[0]), 64'd0);
        idle(2, 1);

        send_frame(30, 44'h0, 1'b1, 1, 0, -1);
        idle(2, 1);
        check_eq("s2_runt", 64'(rc[0]), 64'd1);
        check_eq("s2_no_out", 64'(ov[0]), 64'd0);
        send_frame(44, 44'hFEDCBA98765, 1'b1, 1, 0, -1);
        check_eq("s2_emit", 64'(od[0]), 64'hFEDCBA98765);
        idle(3, 1);

        send_frame(44, 44'h123456789AB, 1'b1, 0, 0, -1);
        idle(3, 0);
        send_frame(44, 44'h55555555555, 1'b1, 0, 0, -1);
        check_eq("s3_hold", 64'(od[0]), 64'h123456789AB);
        check_eq("s3_drop", 64'(dc[0]), 64'd1);
        idle(2, 1);
        check_eq("s3_clear", 64'(ov[0]), 64'd0);

        send_frame(60, 44'hABCDEF01234, 1'b1, 1, 9, -1);
        idle(2, 1);
        check_eq("s4_runt", 64'(rc[0]), 64'd0);
        check_eq("s4_no_out", 64'(ov[0]), 64'd0);
        send_frame(44, 44'h0F0F0F0F0F0, 1'b1, 1, 0, -1);
        check_eq("s4_emit", 64'(od[0]), 64'h0F0F0F0F0F0);
        idle(2, 1);

        send_frame(60, 44'h13579BDF024, 1'b1, 1, 0, -1);
        check_eq("s5_not_yet", 64'(ov[1]), 64'd0);
        idle(1, 1);
        check_eq("s5_end_emit", 64'(ov[1]), 64'd1);
        check_eq("s5_word", 64'(od[1]), 64'h13579BDF024);
        idle(2, 1);
        send_frame(60, 44'h2468ACE1357, 1'b0, 1, 0, -1);
        idle(2, 1);
        check_eq("s5_bad", 64'(bc[1]), 64'd1);
        check_eq("s5_no_out", 64'(ov[1]), 64'd0);

        send_frame(100, 44'h11111111111, 1'b1, 0, 0, -1);
        idle(2, 0);
        send_frame(44, 44'h33333333333, 1'b1, 0, 0, 43);
        check_eq("s6_b2b_valid", 64'(ov[0]), 64'd1);
        check_eq("s6_b2b_word", 64'(od[0]), 64'h33333333333);
        check_eq("s6_no_drop", 64'(dc[0]), 64'd0);
        idle(3, 1);

        for (int f = 0; f < 200; f++) begin
            n  = $urandom_range(0, 100);
            w  = {12'($urandom), $urandom};
            rb = (n > 0 && $urandom_range(0, 9) == 0) ? $urandom_range(1, n) : 0;
            if (n > 0) send_frame(n, w, 1'($urandom_range(0, 1)), 2, rb, -1);
            idle($urandom_range(1, 4), 2);
        end
        idle(4, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_aggregate.md
Name: frame_aggregate

Overview:
Parametrised successor to the fixed 44-bit dibit aggregator in the Ethernet receive path. It consumes the narrow beat stream that follows preamble/SFD stripping and captures the first OUT_W bits of each frame, MSB-first. It emits that word only when the frame has reached a minimum beat count and, optionally, after an external FCS verdict. The output is a ready/valid holding register, and saturating statistics counters report runt, dropped and bad-FCS frames for the game-state decoder downstream.

Parameters:
IN_W, 2, bits per input beat (2 = RMII dibit); OUT_W must be a multiple of IN_W.
OUT_W, 44, captured word width; CAP_BEATS = OUT_W/IN_W.
MIN_BEATS, 44, beats a frame needs to qualify; must be >= CAP_BEATS.
EMIT_AT_END, 0, 0 = emit on qualifying beat; 1 = emit at frame end, gated by fcs_ok.
CNT_W, 16, width of the statistics counters.

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high; clock clk
axiiv  in  1  input beat valid; a frame is a contiguous run of axiiv=1
axiid  in  IN_W  input beat data
fcs_ok  in  1  FCS verdict, sampled on the first cycle axiiv=0 after a frame (used only when EMIT_AT_END=1)
axior  in  1  downstream ready
axiod  out  OUT_W  captured word
axiov  out  1  output valid
runt_count  out  CNT_W  frames that ended with 0 < beats < MIN_BEATS
drop_count  out  CNT_W  qualifying frames lost because the output register was occupied
bad_fcs_count  out  CNT_W  qualifying frames rejected by fcs_ok=0

Behaviour:
- Reset: state=SYNC. Beat count, shift register, axiod, axiov and all three counters are 0.
- The beat counter saturates at MIN_BEATS, so arbitrarily long frames never wrap.
- SYNC: ignores the input until one cycle with axiiv=0 is seen, then moves to CAPTURE. A frame already in flight at reset release is therefore discarded whole.
- CAPTURE: each beat shifts data into the register ({data, axiid}, so the first beat lands in the MSBs) and increments the count. Reaching CAP_BEATS beats moves to COUNT. If axiiv=0 with count>0, runt_count increments and the count and data clear; the state stays CAPTURE.
- COUNT: each beat increments the count. If axiiv=0 before MIN_BEATS, runt_count increments, count and data clear, and the state returns to CAPTURE.
- Qualifying event: the beat that brings the count to MIN_BEATS, whether it arrives in CAPTURE or COUNT (when MIN_BEATS==CAP_BEATS, COUNT is skipped). The state then moves to TAIL.
- Emit timing, EMIT_AT_END=0: the emit request is issued on the qualifying beat, so axiov rises the cycle after that beat is sampled.
- TAIL: waits for axiiv=0, then clears the count and data and returns to CAPTURE. With EMIT_AT_END=1, on that cycle: fcs_ok=1 issues an emit request (axiov rises the next cycle); fcs_ok=0 increments bad_fcs_count.
- Output register: an emit request loads axiod and sets axiov if axiov=0, or if axiov&axior in the same cycle (back-to-back accept). Otherwise the new word is discarded and drop_count increments; the held word is never overwritten.
- Output hold: axiov/axiod hold until axiov&axior. Then axiov clears next cycle unless a reload happens that same cycle.
- One output at most per frame. The capture register is frozen after CAP_BEATS beats.
- Statistics counters saturate at all-ones.
- rst in mid-frame or with output pending: everything clears at once and the pending word is lost.

Test Plan:
- Defaults. 44-beat frame, first 22 beats 2'b10 then 22 beats 2'b01, axior=1 -> axiod=44'hAAAAAAAAAAA, axiov high exactly one cycle, starting the cycle after beat 44.
- Defaults. 30-beat frame -> axiov never asserts; runt_count=1. A following 44-beat frame emits normally.
- Defaults, axior=0. Two qualifying frames 3 idle cycles apart (first word 44'h123456789AB) -> axiod holds 44'h123456789AB, drop_count=1. Raising axior clears axiov the next cycle.
- Defaults. rst released on beat 10 of a 60-beat frame -> no output and runt_count=0. The next 44-beat frame emits.
- EMIT_AT_END=1. 60-beat frame with fcs_ok=1 at the fall -> axiov rises the cycle after axiiv falls. Same frame with fcs_ok=0 -> no output, bad_fcs_count=1.
- Defaults. 100-beat frame with axior pulsed on the exact cycle a second frame qualifies -> one output per frame, the second word is loaded back-to-back, drop_count=0.
